// File: rtl/mem_arbiter_pkg.sv
// Shared types and sizing for the instruction/data memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_GRANT_INSTR = 2'd1,
        ST_GRANT_DATA  = 2'd2
    } mem_arb_state_t;

    localparam int MEM_ARB_CNT_BITS = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one 16-bit memory port between the
// prefetch (instruction) bus and the load/store (data) bus.
//
//   state          | meaning
//   ST_IDLE        | no grant; arbitrate on requests seen this cycle
//   ST_GRANT_INSTR | memory port driven from the instruction requester
//   ST_GRANT_DATA  | memory port driven from the data requester
//
// Data wins ties unless the instruction side has lost STARVE_LIMIT
// arbitrations in a row, in which case it is forced through.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:1] instr_m_addr,
    input  logic        instr_m_access,
    output logic        instr_m_ack,
    output logic [15:0] instr_m_data_in,
    input  logic [19:1] data_m_addr,
    input  logic [15:0] data_m_data_out,
    input  logic        data_m_access,
    input  logic        data_m_wr_en,
    input  logic [1:0]  data_m_bytesel,
    output logic        data_m_ack,
    output logic [15:0] data_m_data_in,
    output logic [19:1] q_m_addr,
    output logic [15:0] q_m_data_out,
    input  logic [15:0] q_m_data_in,
    output logic        q_m_access,
    input  logic        q_m_ack,
    output logic        q_m_wr_en,
    output logic [1:0]  q_m_bytesel
);

    localparam logic [MEM_ARB_CNT_BITS-1:0] LIMIT = MEM_ARB_CNT_BITS'(STARVE_LIMIT);

    mem_arb_state_t              state, state_nxt;
    logic [MEM_ARB_CNT_BITS-1:0] starve_cnt, starve_cnt_nxt;

    // State and starvation counter registers; reset abandons any access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_cnt_nxt;
        end
    end

    // Arbitration, grant release and starvation bookkeeping.
    always_comb begin
        state_nxt      = state;
        starve_cnt_nxt = starve_cnt;
        case (state)
            ST_IDLE: begin
                if (data_m_access && !(instr_m_access && starve_cnt == LIMIT))
                    state_nxt = ST_GRANT_DATA;
                else if (instr_m_access)
                    state_nxt = ST_GRANT_INSTR;

                if (!instr_m_access || state_nxt == ST_GRANT_INSTR)
                    starve_cnt_nxt = '0;
                else if (state_nxt == ST_GRANT_DATA && starve_cnt != LIMIT)
                    starve_cnt_nxt = starve_cnt + 1'b1;
            end
            ST_GRANT_INSTR: begin
                // A dropped access without ack is a prefetch flush.
                if (q_m_ack || !instr_m_access)
                    state_nxt = ST_IDLE;
            end
            ST_GRANT_DATA: begin
                if (q_m_ack || !data_m_access)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Memory-side mux; everything is held at zero while idle.
    always_comb begin
        q_m_access   = 1'b0;
        q_m_addr     = '0;
        q_m_data_out = '0;
        q_m_wr_en    = 1'b0;
        q_m_bytesel  = 2'b00;
        instr_m_ack  = 1'b0;
        data_m_ack   = 1'b0;
        case (state)
            ST_GRANT_INSTR: begin
                q_m_access  = instr_m_access;
                q_m_addr    = instr_m_addr;
                q_m_bytesel = 2'b11;
                instr_m_ack = q_m_ack;
            end
            ST_GRANT_DATA: begin
                q_m_access   = data_m_access;
                q_m_addr     = data_m_addr;
                q_m_data_out = data_m_data_out;
                q_m_wr_en    = data_m_wr_en;
                q_m_bytesel  = data_m_bytesel;
                data_m_ack   = q_m_ack;
            end
            default: ;
        endcase
    end

    // Read data fans out to both requesters; forced low only while in reset.
    assign instr_m_data_in = reset ? q_m_data_in : 16'h0000;
    assign data_m_data_in  = reset ? q_m_data_in : 16'h0000;

endmodule
